// File: rtl/m_trap_ctrl.sv
// Machine-mode trap controller: accepts traps, saves trap CSRs, redirects the
// PC to mtvec on entry and to mepc on mret, and serves the M-mode CSR port.
//
// state | meaning
// IDLE  | waiting for a trap or mret; traps may be accepted
// ENTRY | trap accepted, redirect to mtvec target issued, pipeline held
// EXIT  | mret taken, redirect to mepc issued, pipeline held
module m_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mtval_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        trap_taken_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o,
  output logic        mie_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;

  typedef enum logic [1:0] {IDLE, ENTRY, EXIT} state_t;

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] mstatus_rd, vec_base;
  logic        is_irq, irq_enabled, accept, do_mret;

  assign is_irq      = mcause_i[31];
  assign irq_enabled = mstatus_mie_q & mie_q[mcause_i[4:0]];
  assign accept      = (state_q == IDLE) & trap_i & (~is_irq | irq_enabled);
  assign do_mret     = (state_q == IDLE) & mret_i & ~accept;
  assign vec_base    = {mtvec_q[31:2], 2'b00};
  assign mstatus_rd  = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  assign trap_taken_o  = accept;
  assign redirect_o    = (state_q == ENTRY) | (state_q == EXIT);
  assign busy_o        = redirect_o;
  assign redirect_pc_o = redirect_pc_q;
  assign mie_o         = mstatus_mie_q;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ENTRY;
          if (is_irq && mtvec_q[1:0] == 2'b01)
            redirect_pc_d = vec_base + {mcause_i[29:0], 2'b00};
          else
            redirect_pc_d = vec_base;
        end else if (do_mret) begin
          state_d       = EXIT;
          redirect_pc_d = mepc_q;
        end
      end
      ENTRY:   state_d = IDLE;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      ADDR_MSTATUS:  csr_rdata_o = mstatus_rd;
      ADDR_MIE:      csr_rdata_o = mie_q;
      ADDR_MTVEC:    csr_rdata_o = mtvec_q;
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      ADDR_MEPC:     csr_rdata_o = mepc_q;
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
      ADDR_MTVAL:    csr_rdata_o = mtval_q;
      default:       csr_rdata_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Trap entry and mret updates take priority over colliding CSR writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
    end else begin
      if (csr_we_i && csr_addr_i == ADDR_MIE)      mie_q      <= csr_wdata_i & MIE_MASK;
      if (csr_we_i && csr_addr_i == ADDR_MTVEC)    mtvec_q    <= csr_wdata_i;
      if (csr_we_i && csr_addr_i == ADDR_MSCRATCH) mscratch_q <= csr_wdata_i;

      if (accept) begin
        mepc_q         <= {pc_i[31:2], 2'b00};
        mcause_q       <= mcause_i;
        mtval_q        <= is_irq ? 32'h0 : mtval_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (csr_we_i && csr_addr_i == ADDR_MEPC)   mepc_q   <= {csr_wdata_i[31:2], 2'b00};
        if (csr_we_i && csr_addr_i == ADDR_MCAUSE) mcause_q <= csr_wdata_i;
        if (csr_we_i && csr_addr_i == ADDR_MTVAL)  mtval_q  <= csr_wdata_i;
        if (do_mret) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (csr_we_i && csr_addr_i == ADDR_MSTATUS) begin
          mstatus_mie_q  <= csr_wdata_i[3];
          mstatus_mpie_q <= csr_wdata_i[7];
        end
      end
    end
  end

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Directed bench for m_trap_ctrl: entry, vectored/masked interrupts, mret,
// collisions and reset during ENTRY, checked with immediate assertions.
module tb_m_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_i;
  logic [31:0] mcause_i;
  logic [31:0] pc_i;
  logic [31:0] mtval_i;
  logic        mret_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        trap_taken_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;
  logic        mie_o;

  int checks = 0;
  int errors = 0;

  m_trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trap_i(trap_i), .mcause_i(mcause_i),
    .pc_i(pc_i), .mtval_i(mtval_i), .mret_i(mret_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .trap_taken_o(trap_taken_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o), .mie_o(mie_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr_i = addr;
    #1;
    check(tag, csr_rdata_o, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
    tick();
    csr_we_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; trap_i = 1'b0; mcause_i = 32'h0; pc_i = 32'h0; mtval_i = 32'h0;
    mret_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = 12'h0; csr_wdata_i = 32'h0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_redirect", {31'b0, redirect_o}, 32'h0);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_mie_o", {31'b0, mie_o}, 32'h0);
    check_csr("rst_mtvec", 12'h305, MTVEC_RST);
    check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
    check_csr("rst_mepc", 12'h341, 32'h0);

    // exception entry
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'hFFFF_FFFF);
    check_csr("mstatus_wr_mask", 12'h300, 32'h0000_1888);
    csr_write(12'h300, 32'h0000_0008);
    check("mie_o_set", {31'b0, mie_o}, 32'h1);
    trap_i = 1'b1; mcause_i = 32'h2; pc_i = 32'h2003; mtval_i = 32'hDEAD;
    #1;
    check("exc_taken", {31'b0, trap_taken_o}, 32'h1);
    tick();
    mcause_i = 32'h5; pc_i = 32'h9000; mtval_i = 32'h1111;  // second trap held in ENTRY
    #1;
    check("exc_redirect", {31'b0, redirect_o}, 32'h1);
    check("exc_busy", {31'b0, busy_o}, 32'h1);
    check("exc_target", redirect_pc_o, 32'h0000_0100);
    check("entry_no_taken", {31'b0, trap_taken_o}, 32'h0);
    check_csr("exc_mepc", 12'h341, 32'h0000_2000);
    check_csr("exc_mcause", 12'h342, 32'h2);
    check_csr("exc_mtval", 12'h343, 32'h0000_DEAD);
    check_csr("exc_mstatus", 12'h300, 32'h0000_1880);
    tick();
    trap_i = 1'b0;
    #1;
    check("exc_idle_redirect", {31'b0, redirect_o}, 32'h0);
    check("exc_idle_busy", {31'b0, busy_o}, 32'h0);
    check_csr("entry_trap_ignored", 12'h342, 32'h2);

    // mret
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    #1;
    check("mret_redirect", {31'b0, redirect_o}, 32'h1);
    check("mret_target", redirect_pc_o, 32'h0000_2000);
    check_csr("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    check("mret_idle", {31'b0, redirect_o}, 32'h0);

    // vectored interrupt
    csr_write(12'h304, 32'hFFFF_FFFF);
    check_csr("mie_wr_mask", 12'h304, 32'h0000_0888);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h305, 32'h0000_0101);
    trap_i = 1'b1; mcause_i = 32'h8000_0007; pc_i = 32'h3000; mtval_i = 32'hBEEF;
    #1;
    check("irq_taken", {31'b0, trap_taken_o}, 32'h1);
    tick();
    trap_i = 1'b0;
    #1;
    check("irq_redirect", {31'b0, redirect_o}, 32'h1);
    check("irq_target", redirect_pc_o, 32'h0000_011C);
    check_csr("irq_mtval", 12'h343, 32'h0);
    check_csr("irq_mcause", 12'h342, 32'h8000_0007);
    check_csr("irq_mepc", 12'h341, 32'h0000_3000);
    tick();

    // masked: MIE = 0 after entry
    trap_i = 1'b1; mcause_i = 32'h8000_0007; pc_i = 32'h4000;
    #1;
    check("mask_mie_taken", {31'b0, trap_taken_o}, 32'h0);
    tick();
    trap_i = 1'b0;
    #1;
    check("mask_mie_redirect", {31'b0, redirect_o}, 32'h0);
    check_csr("mask_mie_mepc", 12'h341, 32'h0000_3000);

    // masked: MIE = 1 but mie bit 7 clear
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h304, 32'h0000_0008);
    trap_i = 1'b1; mcause_i = 32'h8000_0007; pc_i = 32'h4000;
    #1;
    check("mask_bit_taken", {31'b0, trap_taken_o}, 32'h0);
    tick();
    trap_i = 1'b0;
    #1;
    check("mask_bit_redirect", {31'b0, redirect_o}, 32'h0);
    check_csr("mask_bit_mcause", 12'h342, 32'h8000_0007);

    // trap + mret + mepc write collision; mscratch pre-edge then write in ENTRY
    check_csr("mscratch_pre", 12'h340, 32'h0);
    trap_i = 1'b1; mret_i = 1'b1; mcause_i = 32'hB; pc_i = 32'h5004; mtval_i = 32'h1234;
    csr_we_i = 1'b1; csr_addr_i = 12'h341; csr_wdata_i = 32'h5555;
    tick();
    trap_i = 1'b0; mret_i = 1'b0;
    csr_addr_i = 12'h340; csr_wdata_i = 32'hCAFE;
    #1;
    check("coll_redirect", {31'b0, redirect_o}, 32'h1);
    check("coll_target", redirect_pc_o, 32'h0000_0100);
    check("entry_csr_zero_lat", csr_rdata_o, 32'h0);
    tick();
    csr_we_i = 1'b0;
    check_csr("entry_csr_write", 12'h340, 32'h0000_CAFE);
    check_csr("coll_mepc", 12'h341, 32'h0000_5004);
    check_csr("coll_mstatus", 12'h300, 32'h0000_1880);

    // mret vs mstatus write collision
    mret_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'h300; csr_wdata_i = 32'h0;
    tick();
    mret_i = 1'b0; csr_we_i = 1'b0;
    #1;
    check("mret2_target", redirect_pc_o, 32'h0000_5004);
    check_csr("mret2_mstatus", 12'h300, 32'h0000_1888);
    tick();

    // mepc low bits, unmapped address
    csr_write(12'h341, 32'h0000_0007);
    check_csr("mepc_align", 12'h341, 32'h0000_0004);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    check_csr("unmapped", 12'h7C0, 32'h0);

    // reset in ENTRY
    trap_i = 1'b1; mcause_i = 32'h3; pc_i = 32'h6000; mtval_i = 32'h77;
    tick();
    trap_i = 1'b0; rst_i = 1'b1;
    #1;
    check("pre_rst_redirect", {31'b0, redirect_o}, 32'h1);
    tick();
    check("rstent_redirect", {31'b0, redirect_o}, 32'h0);
    check("rstent_busy", {31'b0, busy_o}, 32'h0);
    check("rstent_pc", redirect_pc_o, 32'h0);
    check_csr("rstent_mtvec", 12'h305, MTVEC_RST);
    check_csr("rstent_mepc", 12'h341, 32'h0);
    check_csr("rstent_mcause", 12'h342, 32'h0);
    check_csr("rstent_mtval", 12'h343, 32'h0);
    check_csr("rstent_mscratch", 12'h340, 32'h0);
    check_csr("rstent_mie", 12'h304, 32'h0);
    check_csr("rstent_mstatus", 12'h300, 32'h0000_1800);
    rst_i = 1'b0;
    tick();
    check("post_rst_no_strobe", {31'b0, redirect_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_trap_ctrl.md
# m_trap_ctrl

Machine-mode trap controller for the RV32 core; the consumer of the trap encoder's `trap`/`mcause` outputs. On an accepted trap it saves `mepc`, `mcause`, `mtval` and `mstatus`. It then issues a one-cycle PC redirect to the `mtvec` target. On `mret` it restores `mstatus` and redirects to `mepc`. It also owns the M-mode trap CSRs and serves the CSR read/write port of the execute stage.

## Interface

**Parameters**

- `MTVEC_RESET`, default 32'h0000_0000: reset value of `mtvec`.

**Ports**

- `clk_i` in 1: clock; all state updates on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `trap_i` in 1: trap request from the trap encoder.
- `mcause_i` in 32: cause. Bit 31 = interrupt; bits 4:0 = code.
- `pc_i` in 32: PC of the trapping or interrupted instruction.
- `mtval_i` in 32: faulting address or instruction; exceptions only.
- `mret_i` in 1: `mret` retiring.
- `csr_we_i` in 1: CSR write enable.
- `csr_addr_i` in 12: CSR address.
- `csr_wdata_i` in 32: CSR write data.
- `csr_rdata_o` out 32: CSR read data. Combinational on `csr_addr_i`.
- `trap_taken_o` out 1: combinational; high in the cycle a trap is accepted.
- `redirect_o` out 1: PC redirect strobe, one cycle.
- `redirect_pc_o` out 32: redirect target; valid while `redirect_o` = 1.
- `busy_o` out 1: high in ENTRY/EXIT; the pipeline holds.
- `mie_o` out 1: current `mstatus.MIE`.

## Operation

**CSRs**

- `mstatus` 0x300: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
- `mie` 0x304: only MSIE[3], MTIE[7] and MEIE[11] are writable.
- `mtvec` 0x305: fully writable.
- `mscratch` 0x340: fully writable.
- `mepc` 0x341: fully writable; bits 1:0 are forced to 0 on every write.
- `mcause` 0x342: fully writable.
- `mtval` 0x343: fully writable.
- Unmapped addresses read 0; writes to them are ignored.

**Acceptance (IDLE only)**

- An exception (`mcause_i[31]` = 0) with `trap_i` = 1 is always accepted.
- An interrupt (`mcause_i[31]` = 1) is accepted only if `mstatus.MIE` = 1 and `mie[mcause_i[4:0]]` = 1. Otherwise it is ignored and `trap_taken_o` stays 0.

**Entry update, at the accepting edge**

- `mepc` <= {`pc_i`[31:2], 2'b00}.
- `mcause` <= `mcause_i`.
- `mtval` <= `mtval_i` for an exception, 0 for an interrupt.
- MPIE <= MIE, then MIE <= 0.

**Target**

- BASE = {`mtvec`[31:2], 2'b00}.
- `mtvec`[1:0] = 01 and the trap is an interrupt: target = BASE + 4*`mcause`[30:0], truncated to 32 bits.
- Any other mode value, or any exception: target = BASE.

**mret in IDLE with no accepted trap**

- MIE <= MPIE, MPIE <= 1.
- Target = `mepc` as it stands at that edge.

**FSM states: IDLE, ENTRY, EXIT**

- IDLE → ENTRY on an accepted trap.
- IDLE → EXIT on `mret_i`.
- ENTRY → IDLE unconditionally.
- EXIT → IDLE unconditionally.
- In ENTRY/EXIT, `trap_i` and `mret_i` are ignored.
- The redirect target is latched into a register at the transition edge.

**Simultaneous events**

- Trap and `mret_i` together: the trap wins and the `mret` is dropped.
- A CSR write colliding with a trap-entry update: the trap update wins for `mepc`, `mcause`, `mtval` and `mstatus`. CSR writes to any other CSR complete normally.
- A CSR write colliding with an `mret` update of `mstatus`: the `mret` update wins.
- CSR writes in ENTRY/EXIT are performed.

**Reset**

- All CSRs go to 0, except `mtvec` = `MTVEC_RESET`.
- State → IDLE; `redirect_o`, `busy_o` and `redirect_pc_o` = 0.
- Reset asserted in ENTRY/EXIT aborts the redirect: no strobe is issued after reset.

## Timing

- A trap sampled in IDLE at edge N is accepted at edge N.
- CSR updates are visible via `csr_rdata_o` in cycle N+1.
- `redirect_o` and `busy_o` are 1 during cycle N+1 only; back in IDLE at N+2.
- `mret` has the same 1-cycle latency to `redirect_o`.
- At most one redirect per two cycles.
- `trap_taken_o` is 0 in ENTRY/EXIT.
- `csr_rdata_o` has zero latency and shows the pre-edge values in the writing cycle.

## Test plan

- **Exception entry:** `mtvec` = 0x100, MIE = 1; `trap_i` with `mcause_i` = 0x2, `pc_i` = 0x2003, `mtval_i` = 0xDEAD.
  - Next cycle: `redirect_o` = 1, target 0x100.
  - `mepc` = 0x2000, `mcause` = 2, `mtval` = 0xDEAD, MIE = 0, MPIE = 1.
- **Vectored interrupt:** `mtvec` = 0x101, MIE = 1, `mie` = 0x80; `mcause_i` = 0x8000_0007.
  - Target 0x11C; `mtval` = 0.
- **Masked interrupt:** same as above with MIE = 0, or with `mie` bit 7 = 0.
  - `trap_taken_o` = 0, no redirect, CSRs unchanged.
- **mret:** after the exception entry, pulse `mret_i`.
  - Next cycle: redirect to 0x2000, MIE = 1, MPIE = 1.
- **Collisions:**
  - `trap_i` and `mret_i` in the same cycle: entry only.
  - `csr_we_i` to `mepc` = 0x5555 in the trap cycle: `mepc` = trap value.
  - A second `trap_i` in ENTRY: ignored.
- **Reset:** `rst_i` asserted in ENTRY.
  - Next cycle: `redirect_o` = 0, `busy_o` = 0, all CSRs 0, `mtvec` = `MTVEC_RESET`.
